// File: rtl/logic_op_pkg.sv
// Shared types and the per-bit operation used by the logic-op pipeline.
package logic_op_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_XNOR = 2'b11
    } op_e;

    // Applied bit by bit so the datapath width stays a parameter of the caller.
    function automatic logic logicOpBit(input logic a, input logic b, input op_e op);
        logic res;
        res = 1'b0;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_XNOR: res = ~(a ^ b);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/logic_op_fifo.sv
// Result buffer: power-of-two circular FIFO whose head reads as zero when empty.
module logic_op_fifo
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [LVL_W-1:0] o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [LVL_W-1:0] r_level;

    // Pointers are exactly PTR_W bits, so DEPTH-1 + 1 wraps to 0 naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (i_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (i_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wrPtr] <= i_data;
    end

    always_comb begin
        o_data  = (r_level != '0) ? r_mem[r_rdPtr] : '0;
        o_level = r_level;
    end

endmodule

// File: rtl/logic_op_pipe.sv
// Bitwise logic-op unit feeding a small result FIFO, with a saturating all-ones match counter.
module logic_op_pipe
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_r,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] match_cnt,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] w_result;
    logic             w_accept;
    logic             w_pop;
    logic [LVL_W-1:0] w_level;
    logic [CNT_W-1:0] r_matchCnt;

    always_comb begin
        w_result = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_result[i] = logicOpBit(a[i], b[i], op);
        end
    end

    // Readiness depends only on registered level, so a pop cannot free a slot in the same cycle.
    always_comb begin
        in_ready  = rst_n && (w_level < LVL_W'(DEPTH));
        out_valid = (w_level != '0);
        w_accept  = in_valid && in_ready;
        w_pop     = out_valid && out_ready;
        level     = w_level;
        match_cnt = r_matchCnt;
    end

    logic_op_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_data  (w_result),
        .i_pop   (w_pop),
        .o_data  (out_r),
        .o_level (w_level)
    );

    // Clear wins over a coincident match; the count sticks at its maximum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_matchCnt <= '0;
        end else if (clr_cnt) begin
            r_matchCnt <= '0;
        end else if (w_accept && (w_result == '1) && (r_matchCnt != '1)) begin
            r_matchCnt <= r_matchCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed bench for logic_op_pipe: a queue-based reference model checked every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_logic_op_pipe;
   import logic_op_pkg::*;

   localparam int WIDTH   = 8;
   localparam int DEPTH   = 2;
   localparam int CNT_W   = 2;
   localparam int LVL_W   = $clog2(DEPTH) + 1;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   op_e              op;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_r;
   logic             out_valid;
   logic             out_ready;
   logic             clr_cnt;
   logic [CNT_W-1:0] match_cnt;
   logic [LVL_W-1:0] level;

   int nChecks = 0;
   int nFails  = 0;

   logic [WIDTH-1:0] modelQ[$];
   int               modelCnt = 0;

   logic_op_pipe #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .op        (op),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_r     (out_r),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .clr_cnt   (clr_cnt),
      .match_cnt (match_cnt),
      .level     (level)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Inputs change just after the falling edge, then we wait for the next falling edge.
   task automatic applyStimulus(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                                input logic [1:0] iop, input logic ordy, input logic clr,
                                input logic rstn);
      #1;
      in_valid  = v;
      a         = ia;
      b         = ib;
      op        = op_e'(iop);
      out_ready = ordy;
      clr_cnt   = clr;
      rst_n     = rstn;
      @(negedge clk);
   endtask

   function automatic logic [WIDTH-1:0] modelOp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                input logic [1:0] sel);
      case (sel)
         2'd0:    return x & y;
         2'd1:    return x | y;
         2'd2:    return x ^ y;
         default: return ~(x ^ y);
      endcase
   endfunction

   // Reference model: a queue of pending results and a plain integer counter.
   always @(posedge clk) begin : modelUpdate
      bit               acc;
      bit               pop;
      logic [WIDTH-1:0] res;
      if (!rst_n) begin
         modelQ.delete();
         modelCnt = 0;
      end else begin
         acc = in_valid && (modelQ.size() < DEPTH);
         pop = out_ready && (modelQ.size() != 0);
         res = modelOp(a, b, op);
         if (pop) void'(modelQ.pop_front());
         if (acc) modelQ.push_back(res);
         if (clr_cnt) modelCnt = 0;
         else if (acc && res == 8'hFF && modelCnt < CNT_MAX) modelCnt++;
      end
   end

   // Every falling edge, all outputs are compared against the model.
   always @(negedge clk) begin : compare
      logic [WIDTH-1:0] expHead;
      expHead = '0;
      if (modelQ.size() != 0) expHead = modelQ[0];
      checkOutput("in_ready",  32'(in_ready),  32'(rst_n && (modelQ.size() < DEPTH)));
      checkOutput("out_valid", 32'(out_valid), 32'(modelQ.size() != 0));
      checkOutput("out_r",     32'(out_r),     32'(expHead));
      checkOutput("level",     32'(level),     32'(modelQ.size()));
      checkOutput("match_cnt", 32'(match_cnt), 32'(modelCnt));
   end

   initial begin
      logic [7:0] opExp [4];
      logic [1:0] cntExp [5];
      opExp  = '{8'h30, 8'hFC, 8'hCC, 8'h33};
      cntExp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      op        = OP_AND;
      out_ready = 1'b0;
      clr_cnt   = 1'b0;
      @(negedge clk);
      checkOutput("reset in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);

      applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);
      checkOutput("post-reset out_valid", 32'(out_valid), 32'd0);

      // Each op on F0/3C, consumer always ready.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'hF0, 8'h3C, 2'(i), 1'b1, 1'b0, 1'b1);
         checkOutput("op result", 32'(out_r), 32'(opExp[i]));
         checkOutput("op valid", 32'(out_valid), 32'd1);
      end
      applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1);
      checkOutput("op drained level", 32'(level), 32'd0);

      // Backpressure: third accept attempt must be dropped.
      applyStimulus(1'b1, 8'h0F, 8'hF0, 2'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h0F, 8'h33, 2'd1, 1'b0, 1'b0, 1'b1);
      checkOutput("full level", 32'(level), 32'd2);
      checkOutput("full in_ready", 32'(in_ready), 32'd0);
      applyStimulus(1'b1, 8'h11, 8'h22, 2'd2, 1'b0, 1'b0, 1'b1);
      checkOutput("ignored level", 32'(level), 32'd2);
      checkOutput("held head", 32'(out_r), 32'h00);
      applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1);
      checkOutput("drain second", 32'(out_r), 32'h3F);
      applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1);
      checkOutput("drain empty valid", 32'(out_valid), 32'd0);
      checkOutput("drain empty out_r", 32'(out_r), 32'h00);

      // Streaming accept+pop across several pointer wraps.
      applyStimulus(1'b1, 8'h01, 8'hFF, 2'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 8'(i + 2), 8'hFF, 2'd0, 1'b1, 1'b0, 1'b1);
         checkOutput("stream level", 32'(level), 32'd1);
         checkOutput("stream out_r", 32'(out_r), 32'(i + 2));
      end
      applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1);

      // Match counter saturation and clear priority.
      applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b1, 1'b1);
      checkOutput("cnt cleared", 32'(match_cnt), 32'd0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'hFF, 8'hFF, 2'd0, 1'b1, 1'b0, 1'b1);
         checkOutput("cnt step", 32'(match_cnt), 32'(cntExp[i]));
      end
      applyStimulus(1'b1, 8'hFF, 8'hFF, 2'd0, 1'b1, 1'b1, 1'b1);
      checkOutput("cnt clear wins", 32'(match_cnt), 32'd0);
      applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1);

      // Reset with a full buffer and a pending accept.
      applyStimulus(1'b1, 8'hFF, 8'hFF, 2'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h12, 8'h34, 2'd1, 1'b0, 1'b0, 1'b1);
      checkOutput("pre-reset level", 32'(level), 32'd2);
      checkOutput("pre-reset cnt", 32'(match_cnt), 32'd1);
      applyStimulus(1'b1, 8'hFF, 8'hFF, 2'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("in-reset level", 32'(level), 32'd0);
      checkOutput("in-reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("in-reset out_r", 32'(out_r), 32'h00);
      checkOutput("in-reset cnt", 32'(match_cnt), 32'd0);
      checkOutput("in-reset in_ready", 32'(in_ready), 32'd0);
      applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("after-reset in_ready", 32'(in_ready), 32'd1);
      checkOutput("after-reset out_valid", 32'(out_valid), 32'd0);
      applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
